// File: rtl/pc_sequencer.sv
// Next-PC controller: boot hold, stall and trap sequencing, plus the saved epc/cause registers.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned branch/jump targets raise a trap).
module pc_sequencer #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int unsigned     BOOT_HOLD = 4,
    localparam int unsigned    CAUSE_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    curr_addr_i,
    output logic [XLEN-1:0]    next_addr_o,
    input  logic               branch_taken_i,
    input  logic [XLEN-1:0]    branch_target_i,
    input  logic               jump_i,
    input  logic [XLEN-1:0]    jump_target_i,
    input  logic               stall_i,
    input  logic               trap_req_i,
    input  logic [CAUSE_W-1:0] trap_cause_i,
    input  logic               mret_i,
    output logic [XLEN-1:0]    epc_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic               fetch_valid_o,
    output logic               misalign_fault_o,
    output logic [1:0]         state_o
);

    localparam int unsigned CNT_W = $clog2(BOOT_HOLD + 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_TRAP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   boot_cnt_q, boot_cnt_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               boot_done;
    logic               trap_ev;
    logic               mis_ev;
    logic [XLEN-1:0]    jump_tgt;
    logic [XLEN-1:0]    branch_tgt;

    assign boot_done = (boot_cnt_q == CNT_W'(BOOT_HOLD - 1));
    assign trap_ev   = trap_req_i && ((state_q == ST_RUN) || (state_q == ST_STALL));

`ifdef PC_MISALIGN_TRAP_EN
    logic fault_q;
    logic fault_d;

    // Raw targets; a misaligned taken branch/jump in RUN becomes a cause-0 trap.
    assign jump_tgt   = jump_target_i;
    assign branch_tgt = branch_target_i;
    assign mis_ev     = (state_q == ST_RUN) &&
                        ((jump_i && (jump_target_i[1:0] != 2'b00)) ||
                         (branch_taken_i && (branch_target_i[1:0] != 2'b00)));
    assign fault_d    = mis_ev && !trap_ev;
    assign misalign_fault_o = fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // Targets are silently word-aligned instead of faulting.
    assign jump_tgt   = jump_target_i & ALIGN_MASK;
    assign branch_tgt = branch_target_i & ALIGN_MASK;
    assign mis_ev     = 1'b0;
    assign misalign_fault_o = 1'b0;
`endif

    // State and saved-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            epc_q      <= '0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                if (boot_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (trap_ev || mis_ev) begin
                    state_d = ST_TRAP;
                end else if (mret_i || jump_i || branch_taken_i) begin
                    state_d = ST_RUN;
                end else if (stall_i) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (trap_ev) begin
                    state_d = ST_TRAP;
                end else if (!stall_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Next-PC select, fetch qualifier and context capture.
    always_comb begin
        next_addr_o   = curr_addr_i + XLEN'(4);
        fetch_valid_o = 1'b0;
        epc_d         = epc_q;
        cause_d       = cause_q;
        boot_cnt_d    = '0;
        if (rst) begin
            next_addr_o = RESET_VEC;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    next_addr_o = RESET_VEC;
                    boot_cnt_d  = boot_done ? '0 : boot_cnt_q + CNT_W'(1);
                end
                ST_RUN: begin
                    fetch_valid_o = 1'b1;
                    if (trap_ev) begin
                        next_addr_o = TRAP_VEC;
                        epc_d       = curr_addr_i;
                        cause_d     = trap_cause_i;
                    end else if (mis_ev) begin
                        next_addr_o = TRAP_VEC;
                        epc_d       = curr_addr_i;
                        cause_d     = '0;
                    end else if (mret_i) begin
                        next_addr_o = epc_q;
                    end else if (jump_i) begin
                        next_addr_o = jump_tgt;
                    end else if (branch_taken_i) begin
                        next_addr_o = branch_tgt;
                    end else if (stall_i) begin
                        next_addr_o = curr_addr_i;
                    end
                end
                ST_STALL: begin
                    next_addr_o = curr_addr_i;
                    if (trap_ev) begin
                        next_addr_o = TRAP_VEC;
                        epc_d       = curr_addr_i;
                        cause_d     = trap_cause_i;
                    end
                end
                ST_TRAP: begin
                    next_addr_o = TRAP_VEC;
                end
            endcase
        end
    end

    assign epc_o   = epc_q;
    assign cause_o = cause_q;
    assign state_o = state_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the single-cycle core. It drives the `next_addr` input of the PC register from the current PC and the control events raised by decode and execute. Those events are sequential increment, branch, jump, trap entry, trap return and stall. It owns a small FSM for boot hold, stall and trap entry, and the saved exception PC and cause registers.

## Interface
- `XLEN`, 32, address width
- `RESET_VEC`, 32'h0000_0000, first fetch address after boot
- `TRAP_VEC`, 32'h0000_0100, trap handler entry address
- `BOOT_HOLD`, 4, cycles held in BOOT after reset release (>=1)

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `curr_addr`  in  XLEN  current PC from the PC register
- `next_addr`  out  XLEN  next PC; combinational, latched by the PC register
- `branch_taken`  in  1  conditional branch resolved taken
- `branch_target`  in  XLEN  branch destination
- `jump`  in  1  JAL/JALR
- `jump_target`  in  XLEN  jump destination
- `stall`  in  1  hold current PC
- `trap_req`  in  1  synchronous exception/interrupt request
- `trap_cause`  in  4  cause code for `trap_req`
- `mret`  in  1  return from trap
- `epc`  out  XLEN  saved exception PC
- `cause`  out  4  saved cause
- `fetch_valid`  out  1  instruction at `curr_addr` is to be executed
- `misalign_fault`  out  1  registered one-cycle pulse on misaligned target
- `state`  out  2  FSM state: BOOT=0, RUN=1, STALL=2, TRAP=3

## Operation
- **BOOT:**
  - `next_addr`=`RESET_VEC` and `fetch_valid`=0.
  - A counter increments each cycle.
  - After `BOOT_HOLD` cycles, go to RUN.
  - All event inputs are ignored.
- **RUN:** `fetch_valid`=1. Event priority, highest first, is trap_req > misaligned target (macro) > mret > jump > branch_taken > stall > sequential.
  - **trap:** `epc`<=`curr_addr`, `cause`<=`trap_cause`, `next_addr`=`TRAP_VEC`, go to TRAP.
  - **mret:** `next_addr`=`epc`.
  - **jump:** `next_addr`=`jump_target`.
  - **branch:** `next_addr`=`branch_target`.
  - **stall:** `next_addr`=`curr_addr`, go to STALL.
  - **sequential:** `next_addr`=`curr_addr`+4, truncated to XLEN (wraps 32'hFFFF_FFFC to 0).
- **STALL:**
  - `fetch_valid`=0 and `next_addr`=`curr_addr`.
  - Stay while `stall`=1; return to RUN the cycle after `stall` drops.
  - `trap_req` is still accepted, with the same action as in RUN; branch, jump and mret are ignored.
- **TRAP:** exactly one bubble cycle.
  - `fetch_valid`=0 and `next_addr`=`TRAP_VEC`.
  - Next state is RUN. Inputs are ignored.
- **mret with `epc`:** `epc` is always word-aligned, so mret never raises a fault.
- **Reset values:** state=BOOT, boot counter=0, `epc`=0, `cause`=0, `misalign_fault`=0.
  - During reset, `next_addr`=`RESET_VEC` and `fetch_valid`=0.
  - Reset asserted mid-stall or mid-trap returns to BOOT the next edge, with no epc update.

## Timing
- `next_addr` and `fetch_valid` are combinational from state and inputs: zero-cycle latency to the PC register.
- `epc`, `cause`, `state` and `misalign_fault` update on the `clk` rising edge that accepts the event.
- `fetch_valid` returns to 1 after:
  - `BOOT_HOLD` cycles following reset deassertion.
  - 1 cycle after trap entry.
  - 1 cycle after `stall` deasserts.
- When several event inputs are high in the same cycle, only the highest-priority one acts. The others are dropped and are not queued.

## Configuration
- `PC_MISALIGN_TRAP_EN` **defined:**
  - A taken branch or jump whose target has [1:0]!=0 is treated as a trap with cause 4'd0.
  - `epc`<=`curr_addr`, `next_addr`=`TRAP_VEC`, go to TRAP.
  - `misalign_fault` pulses high for one cycle after the edge.
  - This check ranks directly below `trap_req`.
- `PC_MISALIGN_TRAP_EN` **undefined:**
  - Target bits [1:0] are forced to 00 before use.
  - `misalign_fault` is tied 0.

## Test plan
- **Boot:** rst high 3 cycles, then low -> `next_addr`=0 and `fetch_valid`=0 for exactly 4 cycles, then PC sequence 0, 4, 8, C.
- **Branch priority:** at PC 0x20, assert `jump` (0x80) and `branch_taken` (0x40) together -> `next_addr`=0x80. Branch alone -> 0x40.
- **Trap and return:** at PC 0x30, assert `trap_req` with cause 4'd11 -> `next_addr`=0x100, state TRAP for 1 cycle, `epc`=0x30, `cause`=11. Later assert `mret` -> `next_addr`=0x30.
- **Stall with trap:** stall 3 cycles at PC 0x44 -> PC holds 0x44 and `fetch_valid`=0. `trap_req` in the 2nd stall cycle -> `epc`=0x44, PC=0x100.
- **Wrap:** `curr_addr`=32'hFFFF_FFFC in RUN with no events -> `next_addr`=0.
- **Misaligned jump** to 0x52:
  - With `PC_MISALIGN_TRAP_EN`: PC=0x100, `cause`=0, `misalign_fault` high for 1 cycle.
  - Without the macro: `next_addr`=0x50.
